// File: rtl/operand_stack_if.sv
// Command, status and ALU-side signal bundle for operand_stack.
interface operand_stack_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          push_valid;
  logic [31:0]   push_data;
  logic          pop_req;
  logic          exec_valid;
  logic [3:0]    exec_op;
  logic          ready;
  logic [31:0]   top_data;
  logic [CW-1:0] count;
  logic          err_overflow;
  logic          err_underflow;
  logic          err_badop;
  logic [31:0]   alu_operand_a;
  logic [31:0]   alu_operand_b;
  logic [3:0]    alu_op_select;
  logic [31:0]   alu_result_lo;

  // Command source / ALU provider side
  modport master (
    output push_valid, push_data, pop_req, exec_valid, exec_op, alu_result_lo,
    input  ready, top_data, count, err_overflow, err_underflow, err_badop,
    input  alu_operand_a, alu_operand_b, alu_op_select
  );

  // Stack side
  modport slave (
    input  push_valid, push_data, pop_req, exec_valid, exec_op, alu_result_lo,
    output ready, top_data, count, err_overflow, err_underflow, err_badop,
    output alu_operand_a, alu_operand_b, alu_op_select
  );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack that feeds an external combinational ALU and pushes
// the result back. Sequence: IDLE (accept) -> EXEC (capture) -> WB (push).
module operand_stack #(
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  operand_stack_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [3:0]  SEL_IDLE = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_count, w_count_nxt;
  logic [31:0]   r_top, w_top_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_unf, w_unf_nxt;
  logic          r_bad, w_bad_nxt;
  logic [31:0]   r_opa, w_opa_nxt;
  logic [31:0]   r_opb, w_opb_nxt;
  logic [31:0]   r_result, w_result_nxt;
  logic [3:0]    r_sel, w_sel_nxt;

  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [31:0]   w_wr_data;
  logic          w_is_unary, w_is_binary;
  logic [AW-1:0] w_idx_m2, w_idx_m3;
  logic [31:0]   w_mem_m2, w_mem_m3;

  // Entries second and third from the top (only meaningful when count allows)
  assign w_idx_m2 = AW'(r_count - CW'(2));
  assign w_idx_m3 = AW'(r_count - CW'(3));
  assign w_mem_m2 = r_mem[w_idx_m2];
  assign w_mem_m3 = r_mem[w_idx_m3];

  // Opcode class decode: unary, binary, or unsupported
  always_comb begin
    w_is_unary  = 1'b0;
    w_is_binary = 1'b0;
    unique case (bus.exec_op)
      4'b0000, 4'b1001, 4'b1010, 4'b1011:          w_is_unary  = 1'b1;
      4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000: w_is_binary = 1'b1;
      default: ;
    endcase
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_top_nxt    = r_top;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_bad_nxt    = r_bad;
    w_opa_nxt    = r_opa;
    w_opb_nxt    = r_opb;
    w_result_nxt = r_result;
    w_sel_nxt    = SEL_IDLE;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_count[AW-1:0];
    w_wr_data    = bus.push_data;

    unique case (r_state)
      S_IDLE: begin
        if (bus.exec_valid) begin
          if (!w_is_unary && !w_is_binary) begin
            w_bad_nxt = 1'b1;
          end else if (w_is_unary && (r_count >= CW'(1))) begin
            w_opa_nxt   = r_top;
            w_opb_nxt   = 32'h0;
            w_sel_nxt   = bus.exec_op;
            w_count_nxt = r_count - CW'(1);
            w_top_nxt   = (r_count >= CW'(2)) ? w_mem_m2 : 32'h0;
            w_state_nxt = S_EXEC;
          end else if (w_is_binary && (r_count >= CW'(2))) begin
            w_opa_nxt   = w_mem_m2;
            w_opb_nxt   = r_top;
            w_sel_nxt   = bus.exec_op;
            w_count_nxt = r_count - CW'(2);
            w_top_nxt   = (r_count >= CW'(3)) ? w_mem_m3 : 32'h0;
            w_state_nxt = S_EXEC;
          end else begin
            w_unf_nxt = 1'b1;
          end
        end else if (bus.push_valid) begin
          if (r_count < CW'(DEPTH)) begin
            w_wr_en     = 1'b1;
            w_count_nxt = r_count + CW'(1);
            w_top_nxt   = bus.push_data;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end else if (bus.pop_req) begin
          if (r_count != CW'(0)) begin
            w_count_nxt = r_count - CW'(1);
            w_top_nxt   = (r_count >= CW'(2)) ? w_mem_m2 : 32'h0;
          end else begin
            w_unf_nxt = 1'b1;
          end
        end
      end
      S_EXEC: begin
        w_result_nxt = bus.alu_result_lo;
        w_state_nxt  = S_WB;
      end
      S_WB: begin
        // Exec consumed at least one entry, so this push always has room
        w_wr_en     = 1'b1;
        w_wr_data   = r_result;
        w_count_nxt = r_count + CW'(1);
        w_top_nxt   = r_result;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State and control/status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_top    <= 32'h0;
      r_ready  <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_bad    <= 1'b0;
      r_opa    <= 32'h0;
      r_opb    <= 32'h0;
      r_result <= 32'h0;
      r_sel    <= SEL_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_top    <= w_top_nxt;
      r_ready  <= w_ready_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_bad    <= w_bad_nxt;
      r_opa    <= w_opa_nxt;
      r_opb    <= w_opb_nxt;
      r_result <= w_result_nxt;
      r_sel    <= w_sel_nxt;
    end
  end

  // Stack storage; contents are not reset, count alone governs validity
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  assign bus.ready         = r_ready;
  assign bus.top_data      = r_top;
  assign bus.count         = r_count;
  assign bus.err_overflow  = r_ovf;
  assign bus.err_underflow = r_unf;
  assign bus.err_badop     = r_bad;
  assign bus.alu_operand_a = r_opa;
  assign bus.alu_operand_b = r_opb;
  assign bus.alu_op_select = r_sel;
endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: directed scenarios followed by
// random command streams, compared against a queue-based reference model.
module tb_operand_stack;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_stack_if #(.DEPTH(DEPTH)) bus ();

  operand_stack #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference ALU behaviour; op_select 1111 yields a marker value
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b0000: return a + 32'd1;
      4'b0001: return a + b;
      4'b0010: return a - b;
      4'b0110: return a & b;
      4'b0111: return a | b;
      4'b1000: return a ^ b;
      4'b1001: return 32'd0 - a;
      4'b1010: return a << 1;
      4'b1011: return a >> 1;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Bench-side ALU
  always_comb bus.alu_result_lo = alu_ref(bus.alu_op_select, bus.alu_operand_a, bus.alu_operand_b);

  // Reference model state
  logic [31:0] q[$];
  bit          m_ovf, m_unf, m_bad;
  int          busy;
  logic [31:0] m_a, m_b, m_pend;
  logic [3:0]  m_sel;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".ready"}, 32'(bus.ready), 32'(busy == 0));
    check({ctx, ".count"}, 32'(bus.count), 32'(q.size()));
    check({ctx, ".top"},   bus.top_data, (q.size() != 0) ? q[$] : 32'h0);
    check({ctx, ".ovf"},   32'(bus.err_overflow),  32'(m_ovf));
    check({ctx, ".unf"},   32'(bus.err_underflow), 32'(m_unf));
    check({ctx, ".bad"},   32'(bus.err_badop),     32'(m_bad));
    check({ctx, ".sel"},   32'(bus.alu_op_select), 32'(m_sel));
    check({ctx, ".opa"},   bus.alu_operand_a, m_a);
    check({ctx, ".opb"},   bus.alu_operand_b, m_b);
  endtask

  // One clock of stimulus, model update, then full comparison
  task automatic step(input string ctx, input bit r, input bit pv, input logic [31:0] pd,
                      input bit pr, input bit ev, input logic [3:0] eo);
    rst            = r;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_req    = pr;
    bus.exec_valid = ev;
    bus.exec_op    = eo;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_bad = 1'b0;
      busy = 0; m_a = 32'h0; m_b = 32'h0; m_sel = 4'hF;
    end else if (busy == 2) begin
      busy  = 1;
      m_sel = 4'hF;
    end else if (busy == 1) begin
      busy = 0;
      q.push_back(m_pend);
    end else if (ev) begin
      if (eo inside {4'd0, 4'd9, 4'd10, 4'd11}) begin
        if (q.size() >= 1) begin
          m_a = q.pop_back(); m_b = 32'h0;
          m_pend = alu_ref(eo, m_a, m_b); m_sel = eo; busy = 2;
        end else m_unf = 1'b1;
      end else if (eo inside {4'd1, 4'd2, 4'd6, 4'd7, 4'd8}) begin
        if (q.size() >= 2) begin
          m_b = q.pop_back(); m_a = q.pop_back();
          m_pend = alu_ref(eo, m_a, m_b); m_sel = eo; busy = 2;
        end else m_unf = 1'b1;
      end else begin
        m_bad = 1'b1;
      end
    end else if (pv) begin
      if (q.size() < DEPTH) q.push_back(pd);
      else m_ovf = 1'b1;
    end else if (pr) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1'b1;
    end
    #1;
    rst            = 1'b0;
    bus.push_valid = 1'b0;
    bus.pop_req    = 1'b0;
    bus.exec_valid = 1'b0;
    check_all(ctx);
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic push(input string ctx, input logic [31:0] d);
    step(ctx, 1'b0, 1'b1, d, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask

  bit          r_bit, pv_bit, pr_bit, ev_bit;
  logic [31:0] rnd_d;
  logic [3:0]  rnd_op;

  initial begin
    rst = 1'b1;
    bus.push_valid = 1'b0; bus.push_data = 32'h0; bus.pop_req = 1'b0;
    bus.exec_valid = 1'b0; bus.exec_op = 4'h0;
    m_ovf = 1'b0; m_unf = 1'b0; m_bad = 1'b0;
    busy = 0; m_a = 32'h0; m_b = 32'h0; m_pend = 32'h0; m_sel = 4'hF;

    // Reset state
    do_reset();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_sel", 32'(bus.alu_op_select), 32'hF);

    // 7 - 5 = 2 with two busy cycles
    push("sub_p7", 32'd7);
    push("sub_p5", 32'd5);
    step("sub_exec", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0010);
    check("sub_ready_n1", 32'(bus.ready), 32'd0);
    check("sub_sel_exec", 32'(bus.alu_op_select), 32'b0010);
    idle("sub_exec_cyc");
    check("sub_ready_n2", 32'(bus.ready), 32'd0);
    idle("sub_wb_cyc");
    check("sub_top", bus.top_data, 32'd2);
    check("sub_count", 32'(bus.count), 32'd1);

    // IINC wrap-around
    do_reset();
    push("inc_p", 32'hFFFF_FFFF);
    step("inc_exec", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0000);
    idle("inc_e"); idle("inc_w");
    check("inc_top", bus.top_data, 32'h0);
    check("inc_count", 32'(bus.count), 32'd1);

    // Overflow and empty-pop underflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) push("ovf_fill", 32'(100 + i));
    push("ovf_extra", 32'd1);
    check("ovf_flag", 32'(bus.err_overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'(DEPTH));
    check("ovf_top", bus.top_data, 32'(100 + DEPTH - 1));
    do_reset();
    step("pop_empty", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0);
    check("pop_empty_unf", 32'(bus.err_underflow), 32'd1);

    // Exec underflow and bad opcode
    do_reset();
    push("und_p3", 32'd3);
    step("und_iadd", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0001);
    check("und_flag", 32'(bus.err_underflow), 32'd1);
    check("und_top", bus.top_data, 32'd3);
    push("bad_p4", 32'd4);
    step("bad_imul", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0011);
    check("bad_flag", 32'(bus.err_badop), 32'd1);
    check("bad_count", 32'(bus.count), 32'd2);
    check("bad_ready", 32'(bus.ready), 32'd1);

    // Exec beats a simultaneous push
    do_reset();
    push("and_p6", 32'd6);
    push("and_p4", 32'd4);
    step("and_exec", 1'b0, 1'b1, 32'd99, 1'b0, 1'b1, 4'b0110);
    idle("and_e"); idle("and_w");
    check("and_top", bus.top_data, 32'd4);
    check("and_count", 32'(bus.count), 32'd1);

    // Reset during write-back
    do_reset();
    push("ior_p1", 32'd1);
    push("ior_p2", 32'd2);
    step("ior_exec", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0111);
    idle("ior_e");
    step("ior_rst_wb", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
    check("ior_count", 32'(bus.count), 32'd0);
    check("ior_sel", 32'(bus.alu_op_select), 32'hF);
    check("ior_ready", 32'(bus.ready), 32'd1);

    // Random command streams
    for (int i = 0; i < 800; i++) begin
      r_bit  = ($urandom_range(0, 149) == 0);
      pv_bit = 1'($urandom_range(0, 1));
      pr_bit = ($urandom_range(0, 2) == 0);
      ev_bit = ($urandom_range(0, 2) == 0);
      rnd_d  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
      rnd_op = 4'($urandom_range(0, 15));
      step("rand", r_bit, pv_bit, rnd_d, pr_bit, ev_bit, rnd_op);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit stack entries (power of two, >= 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 push_valid  input  1  push push_data onto stack this cycle.
REQ-005 push_data  input  32  value to push.
REQ-006 pop_req  input  1  discard top entry this cycle.
REQ-007 exec_valid  input  1  start ALU operation exec_op on top-of-stack operands.
REQ-008 exec_op  input  4  ALU opcode (same encoding as alu op_select).
REQ-009 ready  output  1  high only in IDLE; commands are accepted only while high.
REQ-010 top_data  output  32  current top entry; 0 when empty.
REQ-011 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-012 err_overflow / err_underflow / err_badop  output  1 each  sticky error flags.
REQ-013 alu_operand_a, alu_operand_b  output  32  operands driven to ALU.
REQ-014 alu_op_select  output  4  opcode driven to ALU.
REQ-015 alu_result_lo  input  32  combinational result from ALU.

Function
REQ-016 The block SHALL implement a LIFO of DEPTH x 32 with FSM states IDLE, EXEC, WB.
REQ-017 Command priority in IDLE SHALL be exec_valid > push_valid > pop_req; lower-priority commands in the same cycle are ignored without flagging.
REQ-018 Commands presented while ready=0 SHALL be ignored with no state or flag change.
REQ-019 Push: count<DEPTH -> entry written, count+1 next cycle; count==DEPTH -> data dropped, err_overflow set.
REQ-020 Pop: count>0 -> count-1; count==0 -> no change, err_underflow set.
REQ-021 Unary ops IINC(0000), INEG(1001), ISHL(1010), ISHR(1011) SHALL need count>=1: operand_a=top, operand_b=0, one entry consumed.
REQ-022 Binary ops IADD(0001), ISUB(0010), IAND(0110), IOR(0111), IXOR(1000) SHALL need count>=2: operand_a=second-from-top, operand_b=top, two entries consumed (result = a op b, JVM order).
REQ-023 Any other exec_op (IMUL, IDIV, IREM, 1100-1111) SHALL set err_badop, leave stack unchanged, remain IDLE.
REQ-024 Exec with insufficient entries SHALL set err_underflow, leave stack unchanged, remain IDLE.
REQ-025 Accepted exec in cycle N: operands and opcode registered at end of N, count reduced at end of N; EXEC during N+1.
REQ-026 In EXEC, alu_op_select SHALL equal the registered opcode; alu_result_lo captured at end of N+1; state -> WB.
REQ-027 In WB (N+2) the captured result SHALL be pushed (count+1) at end of N+2; state -> IDLE; ready=1 and top_data=result in N+3.
REQ-028 Outside EXEC, alu_op_select SHALL be 4'b1111 so every operation presents an op_select change to the ALU; alu_operand_a/b hold last registered values.
REQ-029 WB push SHALL never overflow (net count change of an exec is 0 or -1).
REQ-030 All arithmetic SHALL be 32-bit modulo 2^32 with wrap-around; no carry/overflow reporting.
REQ-031 Error flags SHALL be sticky until rst.

Reset
REQ-032 On rst: state IDLE, count 0, top_data 0, ready 1, all error flags 0, alu_operand_a/b 0, alu_op_select 4'b1111.
REQ-033 rst during EXEC or WB SHALL abort the operation; result discarded, stack empty next cycle.
REQ-034 Stack RAM contents need not be cleared; only count governs validity.

Verification
REQ-035 Push 7, push 5, exec ISUB -> ready low 2 cycles, then top_data=2, count=1, no errors.
REQ-036 Push 32'hFFFFFFFF, exec IINC -> top_data=0, count=1 (wrap-around).
REQ-037 Push DEPTH values then push 1 more -> count=DEPTH, err_overflow=1, top unchanged; pop on empty stack -> err_underflow=1.
REQ-038 Push 3, exec IADD -> err_underflow=1, count=1, top_data=3; exec IMUL with count=2 -> err_badop=1, count=2.
REQ-039 push_valid and exec_valid together in IDLE with stack {4,6} and IAND -> push ignored, top_data=4, count=1.
REQ-040 Assert rst during WB of an IOR -> next cycle count=0, ready=1, flags 0, alu_op_select=4'b1111.
